soc_clk_strobe_gen: RTL

Parametrised, lock-qualified clock-enable generator for the SoC clock subsystem. It sits directly after the system PLL in the `refclk` domain and derives N_CH independent divided strobes and 50%-duty square outputs. Each channel has its own divide ratio and phase offset, both reconfigurable at run time without glitches. Downstream logic runs from one fast clock with enables, instead of from extra PLL outputs.

---
 rtl/soc_clk_strobe_gen.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/soc_clk_strobe_gen.sv
// soc_clk_strobe_gen: lock-qualified, multi-channel clock-enable generator.
// Each channel produces a one-cycle strobe and a ~50% square wave at
// refclk / max(D,2). Divide ratios can be changed glitch-free at run time.
// Optional feature macro: SOC_CLKGEN_PHASE_EN (per-channel phase offsets).
module soc_clk_strobe_gen #(
    parameter int unsigned           N_CH        = 3,
    parameter int unsigned           CNT_W       = 8,
    parameter logic [N_CH*CNT_W-1:0] DIV_INIT    = {8'd10, 8'd10, 8'd1},
    parameter logic [N_CH*CNT_W-1:0] PHASE_INIT  = {8'd5, 8'd0, 8'd0},
    parameter int unsigned           LOCK_CYCLES = 16,
    parameter int unsigned           CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_ack,
    output logic             ready,
    output logic [N_CH-1:0]  strobe,
    output logic [N_CH-1:0]  sq
);

    localparam int unsigned QW = $clog2(LOCK_CYCLES + 1);
    localparam logic [QW-1:0] LOCK_LAST = QW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {UNLOCK, QUAL, RUN} state_t;

    // D of 0 or 1 would give a degenerate period; clamp to 2.
    function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? CNT_W'(2) : d;
    endfunction

    // Square output is high for the first ceil(Deff/2) counts of a period.
    function automatic logic sq_level(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] c);
        logic [CNT_W:0] half;
        half = ({1'b0, eff_div(d)} + (CNT_W+1)'(1)) >> 1;
        return ({1'b0, c} < half);
    endfunction

`ifdef SOC_CLKGEN_PHASE_EN
    // RUN-entry counter value so that the first strobe lands Peff cycles later.
    function automatic logic [CNT_W-1:0] load_cnt(input logic [CNT_W-1:0] d,
                                                   input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] de;
        logic [CNT_W-1:0] pe;
        de = eff_div(d);
        pe = (p > de - CNT_W'(1)) ? de - CNT_W'(1) : p;
        return (pe == '0) ? '0 : de - pe;
    endfunction
`endif

    state_t          state;
    logic [QW-1:0]   qcnt;
    logic            run_stay;
    logic            run_enter;
    logic            run_next;
    logic            wr_ok;

    logic [CNT_W-1:0] cnt       [N_CH];
    logic [CNT_W-1:0] cnt_n     [N_CH];
    logic [CNT_W-1:0] div_act   [N_CH];
    logic [CNT_W-1:0] div_act_n [N_CH];
    logic [CNT_W-1:0] div_sh    [N_CH];
    logic [N_CH-1:0]  div_pend;
    logic [N_CH-1:0]  div_pend_n;
    logic [N_CH-1:0]  sel;
    logic [N_CH-1:0]  wrap;
    logic [N_CH-1:0]  strobe_n;
    logic [N_CH-1:0]  sq_n;

`ifdef SOC_CLKGEN_PHASE_EN
    logic [CNT_W-1:0] ph_act   [N_CH];
    logic [CNT_W-1:0] ph_act_n [N_CH];
    logic [CNT_W-1:0] ph_sh    [N_CH];
    logic [N_CH-1:0]  ph_pend;
    logic [N_CH-1:0]  ph_pend_n;
`else
    logic unused_phase;
    assign unused_phase = ^{cfg_phase, PHASE_INIT};
`endif

    assign wr_ok     = cfg_wr && (32'(cfg_ch) < N_CH);
    assign run_stay  = (state == RUN) && pll_locked;
    assign run_enter = pll_locked && (((state == QUAL) && (qcnt >= LOCK_LAST)) ||
                                      ((state == UNLOCK) && (LOCK_CYCLES <= 1)));
    assign run_next  = run_stay || run_enter;

    // Lock qualification: LOCK_CYCLES consecutive high samples reach RUN.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= UNLOCK;
            qcnt  <= '0;
            ready <= 1'b0;
        end else begin
            ready <= run_next;
            case (state)
                UNLOCK: begin
                    qcnt <= '0;
                    if (pll_locked) begin
                        if (LOCK_CYCLES <= 1) begin
                            state <= RUN;
                        end else begin
                            state <= QUAL;
                            qcnt  <= QW'(1);
                        end
                    end
                end
                QUAL: begin
                    if (!pll_locked) begin
                        state <= UNLOCK;
                        qcnt  <= '0;
                    end else if (qcnt >= LOCK_LAST) begin
                        state <= RUN;
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end
                RUN: begin
                    qcnt <= '0;
                    if (!pll_locked) state <= UNLOCK;
                end
                default: begin
                    state <= UNLOCK;
                    qcnt  <= '0;
                end
            endcase
        end
    end

    // Per-channel next state: shadow apply policy, counter advance and outputs.
    // A write in the same cycle as an apply point is forwarded straight in.
    always_comb begin
        logic [CNT_W-1:0] ld;
        for (int i = 0; i < N_CH; i++) begin
            ld            = '0;
            sel[i]        = wr_ok && (cfg_ch == CH_W'(i));
            wrap[i]       = (cnt[i] == eff_div(div_act[i]) - CNT_W'(1));
            div_pend_n[i] = div_pend[i] | sel[i];
            div_act_n[i]  = div_act[i];
            // Outside a continuing RUN, or at the period wrap, the new D goes live.
            if (div_pend_n[i] && (!run_stay || wrap[i])) begin
                div_act_n[i]  = sel[i] ? cfg_div : div_sh[i];
                div_pend_n[i] = 1'b0;
            end
`ifdef SOC_CLKGEN_PHASE_EN
            ph_pend_n[i] = ph_pend[i] | sel[i];
            ph_act_n[i]  = ph_act[i];
            // Phase only matters at RUN entry, so it applies only outside RUN.
            if (ph_pend_n[i] && !run_stay) begin
                ph_act_n[i]  = sel[i] ? cfg_phase : ph_sh[i];
                ph_pend_n[i] = 1'b0;
            end
            ld = load_cnt(div_act_n[i], ph_act_n[i]);
`endif
            if (run_stay) begin
                cnt_n[i] = wrap[i] ? '0 : cnt[i] + CNT_W'(1);
            end else begin
                cnt_n[i] = ld;
            end
            strobe_n[i] = run_next && (cnt_n[i] == '0);
            sq_n[i]     = run_next && sq_level(div_act_n[i], cnt_n[i]);
        end
    end

    // Control and configuration state, returned to the build-time values on reset.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                div_act[i] <= DIV_INIT[i*CNT_W +: CNT_W];
`ifdef SOC_CLKGEN_PHASE_EN
                ph_act[i]  <= PHASE_INIT[i*CNT_W +: CNT_W];
`endif
            end
            div_pend <= '0;
`ifdef SOC_CLKGEN_PHASE_EN
            ph_pend  <= '0;
`endif
            cfg_ack  <= 1'b0;
            strobe   <= '0;
            sq       <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                div_act[i] <= div_act_n[i];
`ifdef SOC_CLKGEN_PHASE_EN
                ph_act[i]  <= ph_act_n[i];
`endif
            end
            div_pend <= div_pend_n;
`ifdef SOC_CLKGEN_PHASE_EN
            ph_pend  <= ph_pend_n;
`endif
            cfg_ack  <= wr_ok;
            strobe   <= strobe_n;
            sq       <= sq_n;
        end
    end

    // Counters and shadow data; always reloaded outside RUN, so no reset needed.
    always_ff @(posedge refclk) begin
        for (int i = 0; i < N_CH; i++) begin
            cnt[i] <= cnt_n[i];
            if (sel[i]) begin
                div_sh[i] <= cfg_div;
`ifdef SOC_CLKGEN_PHASE_EN
                ph_sh[i]  <= cfg_phase;
`endif
            end
        end
    end

endmodule
